delay_line_server: RTL and testbench
====================================

// Module: delay_line_server
// PURPOSE
//  Server side of the round-robin arbiter request protocol. It accepts one arbitrated read request
//  (offset + handle), reads one sample from a shared single-port delay-line memory and returns it
//  with a one-cycle server_ready pulse. Each handle owns a circular region written by the sample path.
// PARAMETERS
//  req_data_width     16  width of req_data; read offset in samples (0 = newest sample)
//  handle_width        3  width of req_handle/wr_handle; 2**handle_width regions
//  server_data_width  16  sample width (wr_data, mem_wdata, mem_rdata, server_data)
//  region_width       10  log2 samples per region; mem_addr width = handle_width+region_width
//  mem_latency         1  cycles from mem_rd_en to valid mem_rdata (>=1)
// PORTS
//  clk          in   1    clock
//  reset        in   1    synchronous, active-high reset
//  req          in   1    one-cycle request pulse from arbiter
//  req_data     in   req_data_width     read offset, sampled with req
//  req_handle   in   handle_width       region select, sampled with req
//  server_data  out  server_data_width  read result; valid while server_ready=1, held after
//  server_ready out  1    one-cycle pulse, exactly one per accepted request
//  wr_valid     in   1    sample write strobe; always accepted, max one per cycle
//  wr_handle    in   handle_width       region written
//  wr_data      in   server_data_width  sample written
//  mem_addr     out  handle_width+region_width  registered memory address
//  mem_rd_en    out  1    registered read strobe
//  mem_wr_en    out  1    registered write strobe
//  mem_wdata    out  server_data_width  registered write data
//  mem_rdata    in   server_data_width  read data, valid mem_latency cycles after mem_rd_en
//  proto_err    out  1    sticky: req seen while not IDLE; cleared only by reset
// BEHAVIOUR
//  - Reset: state=IDLE; all wp[h]=0; server_ready, mem_rd_en, mem_wr_en and proto_err = 0.
//    server_data, mem_addr and mem_wdata = 0. Reset mid-read aborts; no server_ready is issued.
//  - States: IDLE -> (req) ISSUE -> (no wr_valid) WAIT -> (count done) IDLE.
//  - IDLE: at edge T with req=1, latch offset and handle, go ISSUE.
//    req in ISSUE or WAIT: request ignored, proto_err<=1.
//  - Write, any state: at an edge with wr_valid=1, drive mem_wr_en<=1,
//    mem_addr<={wr_handle,wp[wr_handle]} and mem_wdata<=wr_data.
//    wp[wr_handle]<=wp+1, wrapping mod 2**region_width. Writes always take priority for the port.
//  - ISSUE: if wr_valid, the write is performed and the state stays ISSUE (read slips one cycle per write).
//    Otherwise mem_rd_en<=1 and mem_addr<={h,(wp[h]-1-off') mod 2**region_width}, where
//    off'=min(offset, 2**region_width-1); go WAIT. wp is read at the issue edge, so earlier writes are visible.
//  - WAIT: writes are allowed. At edge T+2+mem_latency (no write stalls): server_data<=mem_rdata,
//    server_ready<=1, go IDLE. Each stall cycle in ISSUE adds 1 cycle.
//  - mem_rd_en/mem_wr_en are one-cycle pulses and are never both 1. server_ready is low in every other cycle.
//  - The earliest next req is accepted on the edge after server_ready goes high (state already IDLE).
//  - Unsigned modular address arithmetic; the offset is truncated only after clamping.
// TESTING
//  1. Reset, write h=2 data 0x0011..0x0015 (5 writes); req h=2 off=0 -> server_ready at T+3
//     (mem_latency=1), server_data=0x0015; off=4 -> 0x0011.
//  2. wp[1] near wrap: 1026 writes h=1 (region 1024) wrap wp[1] to 2; req off=2 -> mem_addr={1,10'd1023}.
//  3. req with off=5000 -> clamped to 1023; mem_addr={h,wp-1-1023 mod 1024}={h,wp}.
//  4. wr_valid high 3 cycles spanning ISSUE -> mem_rd_en delayed 3 cycles; server_ready at T+6,
//     data reflects the writes.
//  5. Second req during WAIT -> ignored, proto_err=1 sticky, exactly one server_ready pulse.
//  6. reset asserted in WAIT -> no server_ready, all outputs at reset values; next req served normally.

Source files
------------

// File: rtl/delay_line_server_if.sv
// delay_line_server_if - request/response, sample-write and memory-port bundle for delay_line_server
//   req/req_data/req_handle   arbitrated read request (client -> server)
//   server_data/server_ready  read result and one-cycle done pulse (server -> client)
//   wr_valid/wr_handle/wr_data  sample-path write (client -> server)
//   mem_addr/mem_rd_en/mem_wr_en/mem_wdata  registered memory port (server -> memory)
//   mem_rdata                 memory read data (memory -> server)
//   proto_err                 sticky protocol error flag (server -> client)
interface delay_line_server_if #(
    parameter int REQ_DATA_WIDTH    = 16,
    parameter int HANDLE_WIDTH      = 3,
    parameter int SERVER_DATA_WIDTH = 16,
    parameter int REGION_WIDTH      = 10
);
    logic                                 req;
    logic [REQ_DATA_WIDTH-1:0]            req_data;
    logic [HANDLE_WIDTH-1:0]              req_handle;
    logic [SERVER_DATA_WIDTH-1:0]         server_data;
    logic                                 server_ready;
    logic                                 wr_valid;
    logic [HANDLE_WIDTH-1:0]              wr_handle;
    logic [SERVER_DATA_WIDTH-1:0]         wr_data;
    logic [HANDLE_WIDTH+REGION_WIDTH-1:0] mem_addr;
    logic                                 mem_rd_en;
    logic                                 mem_wr_en;
    logic [SERVER_DATA_WIDTH-1:0]         mem_wdata;
    logic [SERVER_DATA_WIDTH-1:0]         mem_rdata;
    logic                                 proto_err;

    modport slave (
        input  req, req_data, req_handle, wr_valid, wr_handle, wr_data, mem_rdata,
        output server_data, server_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, proto_err
    );

    modport master (
        output req, req_data, req_handle, wr_valid, wr_handle, wr_data, mem_rdata,
        input  server_data, server_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, proto_err
    );
endinterface

// File: rtl/delay_line_server.sv
// delay_line_server - serves one delay-line read per request from a shared single-port memory
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    delay_line_server_if.slave: request/response, sample writes, memory port, proto_err
module delay_line_server #(
    parameter int REQ_DATA_WIDTH    = 16,
    parameter int HANDLE_WIDTH      = 3,
    parameter int SERVER_DATA_WIDTH = 16,
    parameter int REGION_WIDTH      = 10,
    parameter int MEM_LATENCY       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    delay_line_server_if.slave   bus
);
    localparam int NUM_HANDLES = 2 ** HANDLE_WIDTH;
    localparam int MAX_OFFSET  = 2 ** REGION_WIDTH - 1;
    localparam int CNT_WIDTH   = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam int ADDR_WIDTH  = HANDLE_WIDTH + REGION_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                         state_q, state_d;
    logic [REGION_WIDTH-1:0]        wp_q [NUM_HANDLES];
    logic [REGION_WIDTH-1:0]        wp_d [NUM_HANDLES];
    logic [REQ_DATA_WIDTH-1:0]      off_q, off_d;
    logic [HANDLE_WIDTH-1:0]        hdl_q, hdl_d;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic [SERVER_DATA_WIDTH-1:0]   srv_data_q, srv_data_d;
    logic                           srv_ready_q, srv_ready_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic                           rd_en_q, rd_en_d;
    logic                           wr_en_q, wr_en_d;
    logic [SERVER_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                           perr_q, perr_d;

    // Offsets beyond the region are clamped to the oldest sample before truncation.
    logic [REGION_WIDTH-1:0]        off_clamp;
    logic [REGION_WIDTH-1:0]        rd_ptr;

    always_comb begin
        if (off_q > REQ_DATA_WIDTH'(MAX_OFFSET)) begin
            off_clamp = REGION_WIDTH'(MAX_OFFSET);
        end else begin
            off_clamp = off_q[REGION_WIDTH-1:0];
        end
        // wp points at the next free slot, so the newest sample sits at wp-1.
        rd_ptr = wp_q[hdl_q] - REGION_WIDTH'(1) - off_clamp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req)                          state_d = ISSUE;
            ISSUE:   if (!bus.wr_valid)                    state_d = WAIT;
            WAIT:    if (cnt_q == CNT_WIDTH'(MEM_LATENCY)) state_d = IDLE;
            default:                                       state_d = IDLE;
        endcase
    end

    always_comb begin
        srv_data_d  = srv_data_q;
        srv_ready_d = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        perr_d      = perr_q | (bus.req && (state_q != IDLE));
        off_d       = off_q;
        hdl_d       = hdl_q;
        cnt_d       = cnt_q;
        wp_d        = wp_q;

        // The sample path owns the memory port whenever it writes; reads slip behind it.
        if (bus.wr_valid) begin
            wr_en_d                = 1'b1;
            addr_d                 = {bus.wr_handle, wp_q[bus.wr_handle]};
            wdata_d                = bus.wr_data;
            wp_d[bus.wr_handle]    = wp_q[bus.wr_handle] + REGION_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    off_d = bus.req_data;
                    hdl_d = bus.req_handle;
                end
            end
            ISSUE: begin
                if (!bus.wr_valid) begin
                    rd_en_d = 1'b1;
                    addr_d  = {hdl_q, rd_ptr};
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // cnt counts WAIT edges; MEM_LATENCY+1 edges after the read strobe the data is valid.
                if (cnt_q == CNT_WIDTH'(MEM_LATENCY)) begin
                    srv_data_d  = bus.mem_rdata;
                    srv_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int h = 0; h < NUM_HANDLES; h++) begin
                wp_q[h] <= '0;
            end
            off_q       <= '0;
            hdl_q       <= '0;
            cnt_q       <= '0;
            srv_data_q  <= '0;
            srv_ready_q <= 1'b0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wdata_q     <= '0;
            perr_q      <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            off_q       <= off_d;
            hdl_q       <= hdl_d;
            cnt_q       <= cnt_d;
            srv_data_q  <= srv_data_d;
            srv_ready_q <= srv_ready_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            wdata_q     <= wdata_d;
            perr_q      <= perr_d;
        end
    end

    assign bus.server_data  = srv_data_q;
    assign bus.server_ready = srv_ready_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_rd_en    = rd_en_q;
    assign bus.mem_wr_en    = wr_en_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.proto_err    = perr_q;
endmodule

// File: tb/tb_delay_line_server.sv
// tb/tb_delay_line_server.sv - directed table-driven bench for delay_line_server
module tb_delay_line_server;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    delay_line_server_if bus ();

    delay_line_server dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with one cycle of read latency.
    logic [15:0] mem [8192];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        logic [2:0]  h;
        logic [15:0] off;
        int          stall;
        logic [12:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wr_burst(input logic [2:0] h, input int n, input logic [15:0] base);
        bus.wr_valid  = 1'b1;
        bus.wr_handle = h;
        for (int i = 0; i < n; i++) begin
            bus.wr_data = base + 16'(i);
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input vec_t v, input string nm);
        int          n_rd;
        int          n_rdy;
        int          both;
        logic [12:0] a;
        logic [15:0] d;
        n_rd  = -1;
        n_rdy = -1;
        both  = 0;
        a     = '0;
        d     = '0;
        bus.req        = 1'b1;
        bus.req_handle = v.h;
        bus.req_data   = v.off;
        @(posedge clk); #1;
        bus.req = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n <= v.stall) begin
                bus.wr_valid  = 1'b1;
                bus.wr_handle = v.h;
                bus.wr_data   = 16'hA0 + 16'(n);
            end else begin
                bus.wr_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.mem_rd_en && bus.mem_wr_en) both++;
            if (bus.mem_rd_en && n_rd < 0) begin
                n_rd = n;
                a    = bus.mem_addr;
            end
            if (bus.server_ready) begin
                n_rdy = n;
                d     = bus.server_data;
                break;
            end
        end
        bus.wr_valid = 1'b0;
        chk({nm, " addr"}, 32'(a), 32'(v.addr));
        chk({nm, " rd_latency"}, 32'(n_rd), 32'(1 + v.stall));
        chk({nm, " ready_latency"}, 32'(n_rdy), 32'(3 + v.stall));
        chk({nm, " data"}, 32'(d), 32'(v.data));
        chk({nm, " rd_wr_overlap"}, 32'(both), 32'd0);
        @(posedge clk); #1;
        chk({nm, " ready_pulse"}, 32'(bus.server_ready), 32'd0);
        chk({nm, " data_held"}, 32'(bus.server_data), 32'(v.data));
    endtask

    initial begin
        int   pulses;
        vec_t v;
        checks = 0;
        errors = 0;

        // handle, offset, write stalls, expected mem_addr, expected data
        vecs[0] = '{3'd2, 16'd0,    0, {3'd2, 10'd4},    16'h0015};
        vecs[1] = '{3'd2, 16'd4,    0, {3'd2, 10'd0},    16'h0011};
        vecs[2] = '{3'd1, 16'd2,    0, {3'd1, 10'd1023}, 16'h43FF};
        vecs[3] = '{3'd1, 16'd0,    0, {3'd1, 10'd1},    16'h4401};
        vecs[4] = '{3'd1, 16'd5000, 0, {3'd1, 10'd2},    16'h4002};
        vecs[5] = '{3'd2, 16'd2,    0, {3'd2, 10'd2},    16'h0013};
        vecs[6] = '{3'd3, 16'd0,    3, {3'd3, 10'd2},    16'h00A3};

        reset          = 1'b1;
        bus.req        = 1'b0;
        bus.req_data   = '0;
        bus.req_handle = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_handle  = '0;
        bus.wr_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("reset server_ready", 32'(bus.server_ready), 32'd0);
        chk("reset mem_rd_en",    32'(bus.mem_rd_en),    32'd0);
        chk("reset mem_wr_en",    32'(bus.mem_wr_en),    32'd0);
        chk("reset proto_err",    32'(bus.proto_err),    32'd0);
        chk("reset server_data",  32'(bus.server_data),  32'd0);
        chk("reset mem_addr",     32'(bus.mem_addr),     32'd0);
        chk("reset mem_wdata",    32'(bus.mem_wdata),    32'd0);

        wr_burst(3'd2, 1, 16'h0011);
        chk("write mem_wr_en", 32'(bus.mem_wr_en), 32'd1);
        chk("write mem_addr",  32'(bus.mem_addr),  32'({3'd2, 10'd0}));
        chk("write mem_wdata", 32'(bus.mem_wdata), 32'h0011);
        wr_burst(3'd2, 4, 16'h0012);
        wr_burst(3'd1, 1026, 16'h4000);
        @(posedge clk); #1;
        chk("write pulse end", 32'(bus.mem_wr_en), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i], $sformatf("vec%0d", i));
        end

        // Second request while WAIT: ignored, sticky error, single response.
        chk("proto_err before", 32'(bus.proto_err), 32'd0);
        bus.req = 1'b1; bus.req_handle = 3'd2; bus.req_data = 16'd0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.req_handle = 3'd1; bus.req_data = 16'd3;
        @(posedge clk); #1;
        bus.req = 1'b0;
        chk("proto_err set", 32'(bus.proto_err), 32'd1);
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            if (bus.server_ready) begin
                pulses++;
                chk("dup req data", 32'(bus.server_data), 32'h0015);
            end
            @(posedge clk); #1;
        end
        chk("dup req pulses", 32'(pulses), 32'd1);
        chk("proto_err sticky", 32'(bus.proto_err), 32'd1);

        // Reset while WAIT aborts the read.
        bus.req = 1'b1; bus.req_handle = 3'd2; bus.req_data = 16'd0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort server_ready", 32'(bus.server_ready), 32'd0);
        chk("abort mem_rd_en",    32'(bus.mem_rd_en),    32'd0);
        chk("abort mem_wr_en",    32'(bus.mem_wr_en),    32'd0);
        chk("abort proto_err",    32'(bus.proto_err),    32'd0);
        chk("abort server_data",  32'(bus.server_data),  32'd0);
        chk("abort mem_addr",     32'(bus.mem_addr),     32'd0);
        chk("abort mem_wdata",    32'(bus.mem_wdata),    32'd0);
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (bus.server_ready) pulses++;
        end
        chk("abort no ready", 32'(pulses), 32'd0);

        // Write pointers were cleared, so h=4 restarts at slot 0.
        wr_burst(3'd4, 1, 16'h0077);
        v = '{3'd4, 16'd0, 0, {3'd4, 10'd0}, 16'h0077};
        do_read(v, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
